// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - rate codes and period reload helper for tick_generator
package tick_gen_pkg;

    localparam logic [1:0] RATE_FAST = 2'b00;
    localparam logic [1:0] RATE_1HZ  = 2'b01;
    localparam logic [1:0] RATE_2S   = 2'b10;
    localparam logic [1:0] RATE_4S   = 2'b11;

    // Wide enough for 4*CLK_HZ-1 at any realistic board clock; callers
    // narrow the result to their own counter width.
    localparam int RELOAD_W = 32;

    // Down-counter load value. The tick spacing is this value plus one.
    function automatic logic [RELOAD_W-1:0] reload(input logic [1:0] rate_sel,
                                                   input int unsigned clk_hz);
        case (rate_sel)
            RATE_FAST: reload = '0;
            RATE_1HZ:  reload = RELOAD_W'(clk_hz - 1);
            RATE_2S:   reload = RELOAD_W'(2 * clk_hz - 1);
            default:   reload = RELOAD_W'(4 * clk_hz - 1);
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchronizer, debouncer and press detector
// Ports:
//   clock, resetp  clock and asynchronous active-high reset
//   raw_n          raw active-low button
//   level          debounced button state, 1 = pressed
//   press_pulse    high for one cycle right after level rises
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic resetp,
    input  logic raw_n,
    output logic level,
    output logic press_pulse
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]      sync_n;
    logic            pressed;
    logic            level_q;
    logic [DB_W-1:0] stable_cnt;

    // Idle value of the button is released (high).
    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            sync_n <= 2'b11;
        end else begin
            sync_n <= {sync_n[0], raw_n};
        end
    end

    assign pressed = ~sync_n[1];

    // The counter only runs while the input disagrees with the accepted
    // level; any agreeing sample throws the partial count away.
    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            stable_cnt <= '0;
            level      <= 1'b0;
            level_q    <= 1'b0;
        end else begin
            level_q <= level;
            if (pressed == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level      <= ~level;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + DB_W'(1);
            end
        end
    end

    assign press_pulse = level & ~level_q;

endmodule

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - periodic / single-step enable pulse for the counter stage
// Ports:
//   clock, resetp  clock (CLOCK_50) and asynchronous active-high reset
//   rate_sel       00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz
//   run            switch, 1 enables periodic ticks (asynchronous)
//   step_n         active-low push button, one tick per press (asynchronous)
//   tick           registered one-cycle enable pulse
//   key_level      debounced button state for an LED
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(4 * CLK_HZ)
) (
    input  logic       clock,
    input  logic       resetp,
    input  logic [1:0] rate_sel,
    input  logic       run,
    input  logic       step_n,
    output logic       tick,
    output logic       key_level
);

    logic [1:0]       run_sync;
    logic             run_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload_val;
    logic             primed;
    logic [1:0]       rate_q;
    logic             periodic_tick;
    logic             step_pulse;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clock      (clock),
        .resetp     (resetp),
        .raw_n      (step_n),
        .level      (key_level),
        .press_pulse(step_pulse)
    );

    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            run_sync <= 2'b00;
        end else begin
            run_sync <= {run_sync[0], run};
        end
    end

    assign run_s      = run_sync[1];
    assign reload_val = CNT_W'(reload(rate_sel, CLK_HZ));

    // A tick only comes from a counter that was loaded for the current rate.
    always_comb begin
        periodic_tick = 1'b0;
        if (run_s && primed && (rate_sel == rate_q) && (cnt == '0)) begin
            periodic_tick = 1'b1;
        end
    end

    // Pausing (run_s=0) freezes cnt and primed so a resume finishes the
    // interrupted period instead of starting a new one.
    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            cnt    <= '0;
            primed <= 1'b0;
            rate_q <= RATE_FAST;
            tick   <= 1'b0;
        end else begin
            rate_q <= rate_sel;
            tick   <= periodic_tick | step_pulse;
            if (run_s) begin
                if (!primed) begin
                    cnt    <= reload_val;
                    primed <= 1'b1;
                end else if (rate_sel != rate_q) begin
                    cnt <= reload_val;
                end else if (cnt == '0) begin
                    cnt <= reload_val;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - self-checking bench for tick_generator
module tb_tick_generator;

    localparam int CLK_HZ = 10;
    localparam int DB     = 4;

    logic       clock    = 1'b0;
    logic       resetp   = 1'b1;
    logic [1:0] rate_sel = 2'b01;
    logic       run      = 1'b0;
    logic       step_n   = 1'b1;
    logic       tick;
    logic       key_level;

    int n_cmp = 0;
    int n_bad = 0;

    tick_generator #(
        .CLK_HZ         (CLK_HZ),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock    (clock),
        .resetp   (resetp),
        .rate_sel (rate_sel),
        .run      (run),
        .step_n   (step_n),
        .tick     (tick),
        .key_level(key_level)
    );

    always #5 clock = ~clock;

    // Behavioural model: inputs seen two edges late, a period is a length in
    // cycles fixed when it starts, a key flips after DB disagreeing samples.
    logic       m_run_d0 = 1'b0, m_run_d1 = 1'b0;
    logic       m_step_d0 = 1'b1, m_step_d1 = 1'b1;
    logic       m_primed = 1'b0;
    int         m_age = 0;
    int         m_len = 1;
    logic [1:0] m_rate_prev = 2'b00;
    logic       m_level = 1'b0, m_level_prev = 1'b0;
    logic       m_hist [DB];
    logic       m_tick = 1'b0;
    logic       pt, sp, all_diff;

    function automatic int period_of(input logic [1:0] r);
        case (r)
            2'b00:   return 1;
            2'b01:   return CLK_HZ;
            2'b10:   return 2 * CLK_HZ;
            default: return 4 * CLK_HZ;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < DB; i++) m_hist[i] = 1'b0;
        forever begin
            @(posedge clock or posedge resetp);
            if (resetp) begin
                m_run_d0 = 0; m_run_d1 = 0; m_step_d0 = 1; m_step_d1 = 1;
                m_primed = 0; m_age = 0; m_len = 1; m_rate_prev = 2'b00;
                m_level = 0; m_level_prev = 0; m_tick = 0;
                for (int i = 0; i < DB; i++) m_hist[i] = 1'b0;
            end else begin
                pt = 0;
                if (m_run_d1) begin
                    if (!m_primed) begin
                        m_primed = 1; m_age = 0; m_len = period_of(rate_sel);
                    end else if (rate_sel != m_rate_prev) begin
                        m_age = 0; m_len = period_of(rate_sel);
                    end else begin
                        m_age++;
                        if (m_age == m_len) begin
                            pt = 1; m_age = 0; m_len = period_of(rate_sel);
                        end
                    end
                end
                m_rate_prev = rate_sel;
                sp = m_level && !m_level_prev;
                m_level_prev = m_level;
                for (int i = DB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = !m_step_d1;
                all_diff = 1;
                for (int i = 0; i < DB; i++) if (m_hist[i] == m_level) all_diff = 0;
                if (all_diff) m_level = !m_level;
                m_run_d1 = m_run_d0;  m_run_d0 = run;
                m_step_d1 = m_step_d0; m_step_d0 = step_n;
                m_tick = pt | sp;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (!resetp) begin
                n_cmp++;
                if (tick !== m_tick || key_level !== m_level) begin
                    n_bad++;
                    $display("FAIL cycle_cmp @%0t: dut tick=%0b key_level=%0b, model tick=%0b key_level=%0b",
                             $time, tick, key_level, m_tick, m_level);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Edges from now until tick is seen high (bounded).
    task automatic edges_to_tick(output int n);
        n = 0;
        do begin
            @(posedge clock); n++; @(negedge clock);
        end while (!tick && n < 200);
    endtask

    task automatic edges_to_level(output int n);
        n = 0;
        do begin
            @(posedge clock); n++; @(negedge clock);
        end while (!key_level && n < 200);
    endtask

    task automatic count_ticks(input int cycles, output int c, output int lvl_max);
        c = 0; lvl_max = 0;
        repeat (cycles) begin
            @(posedge clock); @(negedge clock);
            c += int'(tick);
            if (key_level) lvl_max = 1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, c, lv;
        repeat (3) @(negedge clock);
        check("reset_tick", tick, 0);
        check("reset_key_level", key_level, 0);

        // 1: 1 Hz from reset
        resetp = 0; run = 1; rate_sel = 2'b01;
        edges_to_tick(n); check("s1_first_tick", n, 13);
        edges_to_tick(n); check("s1_period_a", n, 10);
        edges_to_tick(n); check("s1_period_b", n, 10);

        // 2: rate changes
        rate_sel = 2'b00;
        @(posedge clock); @(negedge clock);
        check("s2_change_no_tick", tick, 0);
        count_ticks(10, c, lv); check("s2_fast_every_cycle", c, 10);
        rate_sel = 2'b11;
        edges_to_tick(n); check("s2_slow_first", n, 41);
        edges_to_tick(n); check("s2_slow_period", n, 40);

        // 3: key glitch and press
        run = 0;
        repeat (4) @(negedge clock);
        step_n = 0;
        repeat (3) @(negedge clock);
        step_n = 1;
        count_ticks(15, c, lv);
        check("s3_glitch_ticks", c, 0);
        check("s3_glitch_level", lv, 0);
        step_n = 0;
        edges_to_level(n); check("s3_level_latency", n, 6);
        @(posedge clock); @(negedge clock);
        check("s3_step_tick", tick, 1);
        count_ticks(13, c, lv); check("s3_hold_no_more", c, 0);
        step_n = 1;
        count_ticks(15, c, lv); check("s3_release_no_tick", c, 0);
        check("s3_released_level", key_level, 0);

        // 4: pause at cnt=4 and resume
        rate_sel = 2'b01; run = 1;
        edges_to_tick(n); check("s4_resume_held_period", n, 40);
        repeat (3) @(negedge clock);
        run = 0;
        count_ticks(50, c, lv); check("s4_paused_ticks", c, 0);
        run = 1;
        edges_to_tick(n); check("s4_resume_tick", n, 7);
        edges_to_tick(n); check("s4_after_resume", n, 10);

        // 5: step coincides with periodic tick
        repeat (3) @(negedge clock);
        step_n = 0;
        edges_to_tick(n); check("s5_coincide", n, 7);
        @(posedge clock); @(negedge clock);
        check("s5_single_pulse", tick, 0);
        edges_to_tick(n); check("s5_next_period", n, 9);
        step_n = 1;
        repeat (10) @(negedge clock);

        // 6a: asynchronous reset while tick and key_level are high
        rate_sel = 2'b00; step_n = 0;
        repeat (8) @(negedge clock);
        check("s6a_pre_tick", tick, 1);
        check("s6a_pre_level", key_level, 1);
        #2 resetp = 1;
        #1;
        check("s6a_async_tick", tick, 0);
        check("s6a_async_level", key_level, 0);
        @(negedge clock);
        step_n = 1; rate_sel = 2'b01;
        repeat (2) @(negedge clock);
        resetp = 0;
        edges_to_tick(n); check("s6a_first_tick", n, 13);

        // 6: reset at cnt=6 during debounce
        step_n = 0;
        repeat (3) @(negedge clock);
        #2 resetp = 1;
        #1;
        check("s6_async_tick", tick, 0);
        check("s6_async_level", key_level, 0);
        step_n = 1;
        @(negedge clock);
        resetp = 0;
        edges_to_tick(n); check("s6_first_tick", n, 13);
        edges_to_tick(n); check("s6_period", n, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
